// File: rtl/seq_fetch_unit.sv
// ---------------------------------------------------------------------------
// seq_fetch_unit
//   Fetch stage of the Y86-64 SEQ core. Reads one instruction from a
//   byte-wide instruction memory, one byte per request/valid handshake,
//   splits it into icode/ifun/rA/rB/valC and computes valP.
//
// Parameters
//   IMEM_BYTES      instruction memory size; fetch addresses >= this are an
//                   imem error and are never requested.
//   TIMEOUT_CYCLES  max wait cycles for one byte response (FETCH_TIMEOUT_EN).
//
// Configuration macro
//   FETCH_TIMEOUT_EN  when defined, a per-request wait counter aborts the
//                     fetch with imem_error after TIMEOUT_CYCLES wait cycles.
//                     When undefined the unit waits indefinitely.
//
// Ports
//   clk, rst        clock (posedge), synchronous active-high reset
//   PC, start       fetch address and request pulse (accepted in IDLE only)
//   mem_req/addr    byte read request and its address
//   mem_rdata/valid returned byte; mem_valid completes the request
//   icode..valP     decoded instruction fields, valid from done onward
//   instr_valid     0 when icode > 4'hB
//   imem_error      address out of range or response timeout
//   busy, done      fetch in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------
module seq_fetch_unit #(
  parameter int unsigned IMEM_BYTES     = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] PC,
  input  logic        start,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_valid,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_valid,
  output logic        imem_error,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;

  // Architectural result of one fetch; held until the next accepted start.
  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic        ivalid;
    logic        err;
  } fetch_t;

  localparam fetch_t FETCH_RST = '{
    icode:  4'h0,
    ifun:   4'h0,
    ra:     4'hF,
    rb:     4'hF,
    valc:   64'd0,
    valp:   64'd0,
    ivalid: 1'b1,
    err:    1'b0
  };

  state_t      state, nstate;
  fetch_t      f;
  logic [63:0] base;
  logic [3:0]  idx;     // bytes captured so far (0..10)

  // ---- instruction length / field layout by icode -------------------------
  function automatic logic [3:0] len_of(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:             len_of = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:       len_of = 4'd2;
      4'h7, 4'h8:                   len_of = 4'd9;
      4'h3, 4'h4, 4'h5:             len_of = 4'd10;
      default:                      len_of = 4'd1;
    endcase
  endfunction

  function automatic logic has_reg(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_reg = 1'b1;
      default:                                  has_reg = 1'b0;
    endcase
  endfunction

  // ---- request-side combinational control ---------------------------------
  logic [3:0]  len;
  logic        complete;
  logic [63:0] addr;
  logic        oob;
  logic        req_ok;
  logic        accept;
  logic        timeout;

  // icode is only meaningful once byte 0 has been captured (idx != 0).
  assign len      = len_of(f.icode);
  assign complete = (idx != 4'd0) && (idx == len);
  assign addr     = base + {60'd0, idx};
  assign oob      = addr >= 64'(IMEM_BYTES);
  assign req_ok   = (state == REQ) && !complete && !oob;
  assign accept   = req_ok && mem_valid;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned WCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WCW-1:0] WC_LAST = WCW'(TIMEOUT_CYCLES - 1);

  logic [WCW-1:0] wcnt;

  // Fires on the last allowed wait cycle, so done lands TIMEOUT_CYCLES
  // cycles after the request rises. A response in that cycle still wins.
  assign timeout = req_ok && !mem_valid && (wcnt == WC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
    end else if ((state == IDLE) && start) begin
      wcnt <= '0;
    end else if (accept) begin
      wcnt <= '0;
    end else if (req_ok && !timeout) begin
      wcnt <= wcnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;

  // TIMEOUT_CYCLES only matters with the wait counter; keep it legal here.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_cfg_unused
  end
`endif

  // ---- FSM ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate  = state;
    mem_req = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start) nstate = REQ;
      end
      REQ: begin
        busy    = 1'b1;
        mem_req = req_ok;
        if (complete || oob || timeout) nstate = FIN;
      end
      FIN: begin
        done   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  assign mem_addr = mem_req ? addr : 64'd0;

  // ---- datapath ---------------------------------------------------------------
  // Constant byte index: valC byte 0 sits at instruction byte 1 (jXX/call)
  // or byte 2 (irmovq/rmmovq/mrmovq).
  logic [3:0] cidx;
  logic       is_c8;
  logic       is_c10;

  assign is_c8  = (f.icode == 4'h7) || (f.icode == 4'h8);
  assign is_c10 = (f.icode == 4'h3) || (f.icode == 4'h4) || (f.icode == 4'h5);
  assign cidx   = is_c8 ? (idx - 4'd1) : (idx - 4'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      f    <= FETCH_RST;
      base <= 64'd0;
      idx  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base     <= PC;
            idx      <= 4'd0;
            f.icode  <= 4'h0;
            f.ifun   <= 4'h0;
            f.ra     <= 4'hF;
            f.rb     <= 4'hF;
            f.valc   <= 64'd0;
            f.ivalid <= 1'b1;
            f.err    <= 1'b0;
          end
        end
        REQ: begin
          if (complete) begin
            f.valp <= base + {60'd0, len};
          end else if (oob || timeout) begin
            f.err  <= 1'b1;
            f.valp <= base;
          end else if (accept) begin
            idx <= idx + 4'd1;
            if (idx == 4'd0) begin
              f.icode  <= mem_rdata[7:4];
              f.ifun   <= mem_rdata[3:0];
              f.ivalid <= (mem_rdata[7:4] <= 4'hB);
            end else if ((idx == 4'd1) && has_reg(f.icode)) begin
              f.ra <= mem_rdata[7:4];
              f.rb <= mem_rdata[3:0];
            end else if (is_c8 || is_c10) begin
              f.valc[{cidx[2:0], 3'b000} +: 8] <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign icode       = f.icode;
  assign ifun        = f.ifun;
  assign rA          = f.ra;
  assign rB          = f.rb;
  assign valC        = f.valc;
  assign valP        = f.valp;
  assign instr_valid = f.ivalid;
  assign imem_error  = f.err;

endmodule

// File: tb/tb_seq_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_fetch_unit
//   Random and directed fetches against a byte-array memory with a
//   configurable response delay. Expected fields, request addresses and
//   latency come from an instruction-level model of the Y86-64 encoding.
// ---------------------------------------------------------------------------
module tb_seq_fetch_unit;

`ifdef FETCH_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif
  localparam int IMEM = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] pc = 64'd0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_valid = 1'b0;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valc, valp;
  logic        instr_valid, imem_error, busy, done;

  seq_fetch_unit #(.IMEM_BYTES(IMEM), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .PC(pc), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .icode(icode), .ifun(ifun), .rA(ra), .rB(rb),
    .valC(valc), .valP(valp), .instr_valid(instr_valid),
    .imem_error(imem_error), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:IMEM-1];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---- memory responder: answers after dly wait cycles, noise when idle ----
  int          dly = 0;
  bit          never = 1'b0;
  int          wc = 0;
  logic [63:0] addr_q[$];
  int          unstable = 0;
  int          oob_req = 0;
  logic [63:0] last_addr = 64'd0;

  always @(negedge clk) begin
    if (mem_req && !rst) begin
      if (mem_addr >= 64'(IMEM)) oob_req++;
      if (wc > 0 && mem_addr !== last_addr) unstable++;
      last_addr = mem_addr;
      if (!never && wc == dly) begin
        mem_valid = 1'b1;
        mem_rdata = (mem_addr < 64'(IMEM)) ? mem[mem_addr[9:0]] : 8'h00;
        addr_q.push_back(mem_addr);
        wc = 0;
      end else begin
        mem_valid = 1'b0;
        mem_rdata = 8'($urandom);
        wc++;
      end
    end else begin
      mem_valid = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
      wc = 0;
    end
  end

  // ---- instruction-level reference model ----
  task automatic model(input logic [63:0] p,
                       output logic [3:0] e_ic, output logic [3:0] e_fn,
                       output logic [3:0] e_ra, output logic [3:0] e_rb,
                       output logic [63:0] e_vc, output logic [63:0] e_vp,
                       output logic e_iv, output logic e_er, output int nreq);
    int lens [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
    int ip, len;
    logic [7:0] b0, b1;
    e_ic = 4'h0; e_fn = 4'h0; e_ra = 4'hF; e_rb = 4'hF;
    e_vc = 64'd0; e_vp = p; e_iv = 1'b1; e_er = 1'b0; nreq = 0;
    if (p >= 64'(IMEM)) begin
      e_er = 1'b1;
      return;
    end
    ip   = int'(p);
    b0   = mem[ip];
    e_ic = b0[7:4];
    e_fn = b0[3:0];
    e_iv = (int'(e_ic) <= 11);
    len  = lens[e_ic];
    if (ip + len > IMEM) begin
      e_er = 1'b1;
      nreq = IMEM - ip;
      return;
    end
    nreq = len;
    e_vp = p + 64'(len);
    if (e_ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
      b1   = mem[ip + 1];
      e_ra = b1[7:4];
      e_rb = b1[3:0];
    end
    if (e_ic == 4'h7 || e_ic == 4'h8)
      for (int k = 0; k < 8; k++) e_vc[8*k +: 8] = mem[ip + 1 + k];
    if (e_ic == 4'h3 || e_ic == 4'h4 || e_ic == 4'h5)
      for (int k = 0; k < 8; k++) e_vc[8*k +: 8] = mem[ip + 2 + k];
  endtask

  task automatic chk_reset_vals();
    chk("rst_icode", icode, 4'h0);
    chk("rst_ifun", ifun, 4'h0);
    chk("rst_rA", ra, 4'hF);
    chk("rst_rB", rb, 4'hF);
    chk("rst_valC", valc, 64'd0);
    chk("rst_valP", valp, 64'd0);
    chk("rst_ivalid", instr_valid, 1'b1);
    chk("rst_err", imem_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'd0);
  endtask

  // One complete fetch; optional start pulses mid-fetch and in the FIN cycle.
  task automatic run_fetch(input logic [63:0] p, input int d, input bit extra_start);
    logic [3:0]  e_ic, e_fn, e_ra, e_rb;
    logic [63:0] e_vc, e_vp;
    logic        e_iv, e_er;
    int          nreq, cyc, busy_bad, bad;
    model(p, e_ic, e_fn, e_ra, e_rb, e_vc, e_vp, e_iv, e_er, nreq);
    dly = d;
    addr_q.delete();
    unstable = 0;
    oob_req = 0;
    busy_bad = 0;
    @(negedge clk);
    pc = p;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 500) begin
      if (!busy) busy_bad++;
      if (extra_start && cyc == 2) begin
        start = 1'b1;
        pc = p + 64'h40;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", 64'(cyc), 64'(nreq * (d + 1) + 2));
    chk("done_busy", busy, 1'b0);
    chk("busy_during", 64'(busy_bad), 64'd0);
    chk("imem_error", imem_error, e_er);
    chk("valP", valp, e_vp);
    if (nreq > 0) begin
      chk("icode", icode, e_ic);
      chk("ifun", ifun, e_fn);
      chk("instr_valid", instr_valid, e_iv);
    end
    if (!e_er) begin
      chk("rA", ra, e_ra);
      chk("rB", rb, e_rb);
      chk("valC", valc, e_vc);
    end
    chk("nreq", 64'(addr_q.size()), 64'(nreq));
    bad = 0;
    foreach (addr_q[i]) if (addr_q[i] !== p + 64'(i)) bad++;
    chk("req_addrs", 64'(bad), 64'd0);
    chk("addr_stable", 64'(unstable), 64'd0);
    chk("no_oob_req", 64'(oob_req), 64'd0);
    if (extra_start) start = 1'b1;   // lands in the FIN cycle: ignored
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", done, 1'b0);
    chk("idle_req", mem_req, 1'b0);
    if (extra_start) begin
      @(posedge clk);
      @(negedge clk);
      chk("fin_start_ign", busy, 1'b0);
    end
  endtask

  initial begin
    int          r, ndone;
    logic [63:0] p;
    for (int i = 0; i < IMEM; i++) mem[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;

    // irmovq $0x0123456789ABCDEF, %rsp at 0, zero-wait
    mem[0] = 8'h30; mem[1] = 8'hF4;
    mem[2] = 8'hEF; mem[3] = 8'hCD; mem[4] = 8'hAB; mem[5] = 8'h89;
    mem[6] = 8'h67; mem[7] = 8'h45; mem[8] = 8'h23; mem[9] = 8'h01;
    run_fetch(64'd0, 0, 1'b0);
    chk("irmov_valC", valc, 64'h0123456789ABCDEF);
    chk("irmov_valP", valp, 64'd10);

    // ret at 0x20
    mem[32] = 8'h90;
    run_fetch(64'h20, 0, 1'b0);
    chk("ret_rA", ra, 4'hF);
    chk("ret_valP", valp, 64'h21);

    // invalid icode at 5
    mem[5] = 8'hE0;
    run_fetch(64'd5, 0, 1'b0);
    chk("inv_ivalid", instr_valid, 1'b0);

    // jXX straddling the end of memory
    mem[1020] = 8'h70;
    run_fetch(64'd1020, 0, 1'b0);
    chk("edge_err", imem_error, 1'b1);
    chk("edge_valP", valp, 64'd1020);

    // start beyond memory
    run_fetch(64'd5000, 0, 1'b0);

    // OPq with slow memory plus ignored start pulses
    mem[64] = 8'h60; mem[65] = 8'h12;
    run_fetch(64'h40, 3, 1'b1);
    chk("opq_rA", ra, 4'h1);
    chk("opq_rB", rb, 4'h2);
    chk("opq_valP", valp, 64'h42);

    // reset mid-fetch
    dly = 1;
    @(negedge clk);
    pc = 64'd0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_no_done", 64'(ndone), 64'd0);

`ifdef FETCH_TIMEOUT_EN
    never = 1'b1;
    @(negedge clk);
    pc = 64'h100;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    r = 1;
    while (!done && r < 200) begin
      @(posedge clk);
      @(negedge clk);
      r++;
    end
    chk("to_latency", 64'(r), 64'(TO + 1));
    chk("to_err", imem_error, 1'b1);
    chk("to_valP", valp, 64'h100);
    @(posedge clk);
    @(negedge clk);
    chk("to_req_low", mem_req, 1'b0);
    never = 1'b0;
`endif

    // randomized fetches
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      p = 64'($urandom_range(0, IMEM - 1));
      else if (r < 93) p = 64'($urandom_range(IMEM - 12, IMEM - 1));
      else             p = {32'($urandom), 32'($urandom)} | 64'h400;
      if ($urandom_range(0, 3) == 0 && p < 64'(IMEM))
        mem[p[9:0]] = {4'($urandom_range(0, 11)), 4'($urandom)};
      run_fetch(p, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
